alu_exec_unit: RTL and testbench

// Parametrised execute stage: decodes ALUOp/Funct3/Funct7 into `ALU_* control lines and computes the result.

---
 rtl/alu_exec_unit.sv | 274 +++++++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute stage: decodes ALUOp/Funct3/Funct7, computes single-cycle ALU ops and
// runs RV32M multiply/divide on an iterative shift-add / restoring sequencer.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_valid / o_ready            upstream handshake
//   i_ALUOp, i_Funct3, i_Funct7  decode fields
//   i_OpA, i_OpB                 pre-muxed operands
//   i_Flush                      drop in-flight op and pending result
//   o_valid / i_ready            downstream handshake
//   o_Result                     result
//   o_ALUControlLines            ALU code of the accepted op
//   o_Illegal                    accepted op was undecodable
//   o_Busy                       sequencer not idle
module alu_exec_unit #(
    parameter int XLEN  = 32,
    parameter bit M_EXT = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_ALUOp,
    input  logic [2:0]      i_Funct3,
    input  logic [6:0]      i_Funct7,
    input  logic [XLEN-1:0] i_OpA,
    input  logic [XLEN-1:0] i_OpB,
    input  logic            i_Flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_Result,
    output logic [3:0]      o_ALUControlLines,
    output logic            o_Illegal,
    output logic            o_Busy
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t          state_q;
    logic            valid_q;
    logic [XLEN-1:0] result_q;
    logic            illegal_q;
    logic [3:0]      ctl_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] opnd_q;
    logic [1:0]      f3_q;
    logic            neg_q;
    logic            sa_q;
    logic            dz_q;
    logic [XLEN-1:0] opa_q;

    logic accept;

    assign o_ready           = (state_q == IDLE) && (!valid_q || i_ready) && !i_rst;
    assign accept            = i_valid && o_ready;
    assign o_valid           = valid_q;
    assign o_Result          = result_q;
    assign o_Illegal         = illegal_q;
    assign o_ALUControlLines = ctl_q;
    assign o_Busy            = (state_q != IDLE);

    function automatic logic [3:0] f3_ctl(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f3_ctl = alt ? ALU_SUB : ALU_ADD;
            3'b001:  f3_ctl = ALU_SLL;
            3'b010:  f3_ctl = ALU_SLT;
            3'b011:  f3_ctl = ALU_SLTU;
            3'b100:  f3_ctl = ALU_XOR;
            3'b101:  f3_ctl = alt ? ALU_SRA : ALU_SRL;
            3'b110:  f3_ctl = ALU_OR;
            default: f3_ctl = ALU_AND;
        endcase
    endfunction

    // Decode
    logic [3:0] dec_ctl;
    logic       dec_ill;
    logic       dec_m;
    logic       dec_passb;

    always_comb begin
        dec_ctl   = ALU_ADD;
        dec_ill   = 1'b0;
        dec_m     = 1'b0;
        dec_passb = 1'b0;
        case (i_ALUOp)
            3'b000: dec_ctl = ALU_ADD;
            3'b001: dec_ctl = ALU_SUB;
            3'b100: dec_passb = 1'b1;
            3'b101: dec_ctl = ALU_ADD;
            3'b010: begin
                if (i_Funct7 == 7'b0000000)
                    dec_ctl = f3_ctl(i_Funct3, 1'b0);
                else if (i_Funct7 == 7'b0100000 &&
                         (i_Funct3 == 3'b000 || i_Funct3 == 3'b101))
                    dec_ctl = f3_ctl(i_Funct3, 1'b1);
                else if (i_Funct7 == 7'b0000001 && M_EXT)
                    dec_m = 1'b1;
                else
                    dec_ill = 1'b1;
            end
            3'b011: begin
                // Funct7 is immediate bits except for the shift encodings
                if (i_Funct3 == 3'b001 && i_Funct7 != 7'b0000000)
                    dec_ill = 1'b1;
                else if (i_Funct3 == 3'b101 && i_Funct7 != 7'b0000000 &&
                         i_Funct7 != 7'b0100000)
                    dec_ill = 1'b1;
                else
                    dec_ctl = f3_ctl(i_Funct3, i_Funct3 == 3'b101 && i_Funct7[5]);
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Single-cycle ALU
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;

    assign shamt = i_OpB[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (dec_ctl)
            ALU_ADD:  alu_res = i_OpA + i_OpB;
            ALU_SUB:  alu_res = i_OpA - i_OpB;
            ALU_SLL:  alu_res = i_OpA << shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(i_OpA) < $signed(i_OpB)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, i_OpA < i_OpB};
            ALU_XOR:  alu_res = i_OpA ^ i_OpB;
            ALU_SRL:  alu_res = i_OpA >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(i_OpA) >>> shamt);
            ALU_OR:   alu_res = i_OpA | i_OpB;
            ALU_AND:  alu_res = i_OpA & i_OpB;
            default:  alu_res = '0;
        endcase
        if (dec_passb)
            alu_res = i_OpB;
    end

    // Sequencer setup: operate on magnitudes, fix signs at the end
    logic            m_div;
    logic            sgn_a;
    logic            sgn_b;
    logic            na;
    logic            nb;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    assign m_div = i_Funct3[2];
    assign sgn_a = m_div ? !i_Funct3[0] : (i_Funct3 == 3'b001 || i_Funct3 == 3'b010);
    assign sgn_b = m_div ? !i_Funct3[0] : (i_Funct3 == 3'b001);
    assign na    = sgn_a && i_OpA[XLEN-1];
    assign nb    = sgn_b && i_OpB[XLEN-1];
    assign mag_a = na ? ('0 - i_OpA) : i_OpA;
    assign mag_b = nb ? ('0 - i_OpB) : i_OpB;

    // One iteration step; the final step also feeds the result so the
    // result lands on the same edge as the last iteration.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_rsh;
    logic [XLEN-1:0]   div_sub;
    logic [XLEN-1:0]   hi_n;
    logic [XLEN-1:0]   lo_n;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   seq_out;

    always_comb begin
        hi_n    = hi_q;
        lo_n    = lo_q;
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_rsh = {hi_q, lo_q[XLEN-1]};
        div_sub = div_rsh[XLEN-1:0] - opnd_q;
        if (state_q == MUL) begin
            {hi_n, lo_n} = {mul_sum, lo_q[XLEN-1:1]};
        end else if (state_q == DIV) begin
            if (div_rsh >= {1'b0, opnd_q}) begin
                hi_n = div_sub;
                lo_n = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_n = div_rsh[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b0};
            end
        end
        prod_fix = neg_q ? ('0 - {hi_n, lo_n}) : {hi_n, lo_n};
        quo      = neg_q ? ('0 - lo_n) : lo_n;
        rem      = sa_q ? ('0 - hi_n) : hi_n;
        if (state_q == MUL)
            seq_out = (f3_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else if (dz_q)
            seq_out = f3_q[1] ? opa_q : '1;
        else
            seq_out = f3_q[1] ? rem : quo;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            result_q  <= '0;
            illegal_q <= 1'b0;
            ctl_q     <= ALU_ADD;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            f3_q      <= '0;
            neg_q     <= 1'b0;
            sa_q      <= 1'b0;
            dz_q      <= 1'b0;
            opa_q     <= '0;
        end else if (i_Flush) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        ctl_q     <= dec_ctl;
                        illegal_q <= dec_ill;
                        if (dec_m) begin
                            state_q <= m_div ? DIV : MUL;
                            valid_q <= 1'b0;
                            cnt_q   <= '0;
                            hi_q    <= '0;
                            lo_q    <= m_div ? mag_a : mag_b;
                            opnd_q  <= m_div ? mag_b : mag_a;
                            f3_q    <= i_Funct3[1:0];
                            neg_q   <= na ^ nb;
                            sa_q    <= na;
                            dz_q    <= (i_OpB == '0);
                            opa_q   <= i_OpA;
                        end else begin
                            valid_q  <= 1'b1;
                            result_q <= dec_ill ? '0 : alu_res;
                        end
                    end else if (valid_q && i_ready) begin
                        valid_q <= 1'b0;
                    end
                end
                MUL, DIV: begin
                    hi_q  <= hi_n;
                    lo_q  <= lo_n;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) begin
                        state_q  <= IDLE;
                        valid_q  <= 1'b1;
                        result_q <= seq_out;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit: vector table for ALU/M ops plus
// sequences for backpressure, flush, mid-op reset and an M_EXT=0 build.
module tb_alu_exec_unit;

    localparam logic [3:0] C_ADD  = 4'd0;
    localparam logic [3:0] C_SUB  = 4'd1;
    localparam logic [3:0] C_SLL  = 4'd2;
    localparam logic [3:0] C_SLT  = 4'd3;
    localparam logic [3:0] C_SLTU = 4'd4;
    localparam logic [3:0] C_XOR  = 4'd5;
    localparam logic [3:0] C_SRL  = 4'd6;
    localparam logic [3:0] C_SRA  = 4'd7;
    localparam logic [3:0] C_OR   = 4'd8;
    localparam logic [3:0] C_AND  = 4'd9;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic        i_Flush = 1'b0;
    logic [2:0]  i_ALUOp = '0;
    logic [2:0]  i_Funct3 = '0;
    logic [6:0]  i_Funct7 = '0;
    logic [31:0] i_OpA = '0;
    logic [31:0] i_OpB = '0;

    logic        o_ready, o_valid, o_Illegal, o_Busy;
    logic [31:0] o_Result;
    logic [3:0]  o_ctl;
    logic        o0_ready, o0_valid, o0_Illegal, o0_Busy;
    logic [31:0] o0_Result;
    logic [3:0]  o0_ctl;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .M_EXT(1'b1)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_ALUOp(i_ALUOp), .i_Funct3(i_Funct3), .i_Funct7(i_Funct7),
        .i_OpA(i_OpA), .i_OpB(i_OpB), .i_Flush(i_Flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_Result(o_Result),
        .o_ALUControlLines(o_ctl), .o_Illegal(o_Illegal), .o_Busy(o_Busy)
    );

    alu_exec_unit #(.XLEN(32), .M_EXT(1'b0)) dut0 (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o0_ready),
        .i_ALUOp(i_ALUOp), .i_Funct3(i_Funct3), .i_Funct7(i_Funct7),
        .i_OpA(i_OpA), .i_OpB(i_OpB), .i_Flush(i_Flush),
        .o_valid(o0_valid), .i_ready(i_ready), .o_Result(o0_Result),
        .o_ALUControlLines(o0_ctl), .o_Illegal(o0_Illegal), .o_Busy(o0_Busy)
    );

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
        logic [3:0]  ctl;
        int          lat;
    } vec_t;

    vec_t tv[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        @(negedge clk);
        i_ALUOp  = v.op;
        i_Funct3 = v.f3;
        i_Funct7 = v.f7;
        i_OpA    = v.a;
        i_OpB    = v.b;
        i_valid  = 1'b1;
        i_ready  = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        n = 1;
        while (o_valid !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("v%0d latency", idx), n, v.lat);
        chk($sformatf("v%0d result", idx), o_Result, v.res);
        chk($sformatf("v%0d illegal", idx), {31'b0, o_Illegal}, {31'b0, v.ill});
        chk($sformatf("v%0d ctl", idx), {28'b0, o_ctl}, {28'b0, v.ctl});
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a,
                         input logic [31:0] b);
        i_ALUOp  = op;
        i_Funct3 = f3;
        i_Funct7 = f7;
        i_OpA    = a;
        i_OpB    = b;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        // ALU vectors
        tv.push_back('{3'b010, 3'b000, 7'h00, 32'd5, 32'd7, 32'd12, 1'b0, C_ADD, 1});
        tv.push_back('{3'b010, 3'b000, 7'h20, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, C_SUB, 1});
        tv.push_back('{3'b011, 3'b101, 7'h20, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, C_SRA, 1});
        tv.push_back('{3'b011, 3'b101, 7'h10, 32'h80000000, 32'd4, 32'h0, 1'b1, C_ADD, 1});
        tv.push_back('{3'b010, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, C_SLT, 1});
        tv.push_back('{3'b010, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, C_SLTU, 1});
        tv.push_back('{3'b010, 3'b100, 7'h00, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, C_XOR, 1});
        tv.push_back('{3'b010, 3'b101, 7'h00, 32'h80000000, 32'd4, 32'h08000000, 1'b0, C_SRL, 1});
        tv.push_back('{3'b011, 3'b001, 7'h00, 32'd3, 32'h21, 32'd6, 1'b0, C_SLL, 1});
        tv.push_back('{3'b011, 3'b001, 7'h20, 32'd3, 32'h1, 32'd0, 1'b1, C_ADD, 1});
        tv.push_back('{3'b011, 3'b110, 7'h55, 32'h0F, 32'hF0, 32'hFF, 1'b0, C_OR, 1});
        tv.push_back('{3'b010, 3'b111, 7'h00, 32'hFF00, 32'h0F0F, 32'h0F00, 1'b0, C_AND, 1});
        tv.push_back('{3'b100, 3'b000, 7'h00, 32'h55, 32'h12345000, 32'h12345000, 1'b0, C_ADD, 1});
        tv.push_back('{3'b101, 3'b000, 7'h00, 32'h1000, 32'h2000, 32'h3000, 1'b0, C_ADD, 1});
        tv.push_back('{3'b000, 3'b010, 7'h00, 32'h100, 32'hFFFFFFFC, 32'hFC, 1'b0, C_ADD, 1});
        tv.push_back('{3'b001, 3'b000, 7'h00, 32'd3, 32'd3, 32'd0, 1'b0, C_SUB, 1});
        tv.push_back('{3'b110, 3'b000, 7'h00, 32'd3, 32'd3, 32'd0, 1'b1, C_ADD, 1});
        tv.push_back('{3'b010, 3'b001, 7'h20, 32'd3, 32'd3, 32'd0, 1'b1, C_ADD, 1});
        tv.push_back('{3'b010, 3'b000, 7'h02, 32'd3, 32'd3, 32'd0, 1'b1, C_ADD, 1});
        tv.push_back('{3'b011, 3'b000, 7'h7F, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, C_ADD, 1});
        // Multiply group
        tv.push_back('{3'b010, 3'b001, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, C_ADD, 33});
        tv.push_back('{3'b010, 3'b011, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, C_ADD, 33});
        tv.push_back('{3'b010, 3'b000, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 1'b0, C_ADD, 33});
        tv.push_back('{3'b010, 3'b010, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, C_ADD, 33});
        tv.push_back('{3'b010, 3'b000, 7'h01, 32'd6, 32'd7, 32'd42, 1'b0, C_ADD, 33});
        // Divide group
        tv.push_back('{3'b010, 3'b100, 7'h01, 32'd7, 32'd0, 32'hFFFFFFFF, 1'b0, C_ADD, 33});
        tv.push_back('{3'b010, 3'b110, 7'h01, 32'd7, 32'd0, 32'd7, 1'b0, C_ADD, 33});
        tv.push_back('{3'b010, 3'b101, 7'h01, 32'd7, 32'd0, 32'hFFFFFFFF, 1'b0, C_ADD, 33});
        tv.push_back('{3'b010, 3'b111, 7'h01, 32'd7, 32'd0, 32'd7, 1'b0, C_ADD, 33});
        tv.push_back('{3'b010, 3'b100, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, C_ADD, 33});
        tv.push_back('{3'b010, 3'b110, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, C_ADD, 33});
        tv.push_back('{3'b010, 3'b100, 7'h01, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, C_ADD, 33});
        tv.push_back('{3'b010, 3'b110, 7'h01, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, C_ADD, 33});
        tv.push_back('{3'b010, 3'b101, 7'h01, 32'd100, 32'd7, 32'd14, 1'b0, C_ADD, 33});
        tv.push_back('{3'b010, 3'b111, 7'h01, 32'd100, 32'd7, 32'd2, 1'b0, C_ADD, 33});
        tv.push_back('{3'b010, 3'b101, 7'h01, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 1'b0, C_ADD, 33});

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst valid", {31'b0, o_valid}, 32'd0);
        chk("rst result", o_Result, 32'd0);
        chk("rst illegal", {31'b0, o_Illegal}, 32'd0);
        chk("rst ctl", {28'b0, o_ctl}, {28'b0, C_ADD});
        chk("rst ready", {31'b0, o_ready}, 32'd0);
        @(negedge clk);
        i_rst = 1'b0;
        #1;
        chk("ready after rst", {31'b0, o_ready}, 32'd1);

        foreach (tv[i]) run_vec(tv[i], i);

        // Backpressure then back-to-back ADDs
        @(negedge clk);
        drive(3'b010, 3'b000, 7'h00, 32'd1, 32'd1);
        i_valid = 1'b1;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp valid", {31'b0, o_valid}, 32'd1);
        chk("bp result", o_Result, 32'd2);
        i_ready = 1'b0;
        i_OpA   = 32'd100;
        i_OpB   = 32'd100;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp hold%0d result", k), o_Result, 32'd2);
            chk($sformatf("bp hold%0d ready", k), {31'b0, o_ready}, 32'd0);
            chk($sformatf("bp hold%0d valid", k), {31'b0, o_valid}, 32'd1);
        end
        i_ready = 1'b1;
        i_OpA   = 32'd10;
        i_OpB   = 32'd1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b2b%0d valid", k), {31'b0, o_valid}, 32'd1);
            chk($sformatf("b2b%0d result", k), o_Result, 32'(11 * (k + 1)));
            i_OpA = 32'(10 * (k + 2));
            i_OpB = 32'(k + 2);
        end
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b drain valid", {31'b0, o_valid}, 32'd0);

        // Flush 10 cycles into a DIV
        @(negedge clk);
        drive(3'b010, 3'b100, 7'h01, 32'd100, 32'd7);
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        chk("flush busy before", {31'b0, o_Busy}, 32'd1);
        repeat (9) @(posedge clk);
        #1;
        i_Flush = 1'b1;
        @(posedge clk);
        #1;
        i_Flush = 1'b0;
        chk("flush valid", {31'b0, o_valid}, 32'd0);
        chk("flush busy", {31'b0, o_Busy}, 32'd0);
        chk("flush ready", {31'b0, o_ready}, 32'd1);
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (o_valid) cnt++;
        end
        chk("flush no late valid", 32'(cnt), 32'd0);

        // M_EXT=0 build sees MUL as illegal; main DUT runs it normally
        @(negedge clk);
        drive(3'b010, 3'b000, 7'h01, 32'd3, 32'd4);
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        chk("noM valid", {31'b0, o0_valid}, 32'd1);
        chk("noM illegal", {31'b0, o0_Illegal}, 32'd1);
        chk("noM result", o0_Result, 32'd0);
        cnt = 1;
        while (o_valid !== 1'b1 && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("mul3x4 latency", 32'(cnt), 32'd33);
        chk("mul3x4 result", o_Result, 32'd12);

        // Reset in the middle of a MUL
        @(negedge clk);
        drive(3'b010, 3'b011, 7'h01, 32'd9, 32'd9);
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        chk("midrst busy", {31'b0, o_Busy}, 32'd0);
        chk("midrst valid", {31'b0, o_valid}, 32'd0);
        chk("midrst result", o_Result, 32'd0);
        chk("midrst ctl", {28'b0, o_ctl}, {28'b0, C_ADD});
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (o_valid) cnt++;
        end
        chk("midrst no late valid", 32'(cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
